truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequencer that characterises a single-output N-input combinational gate netlist by sweeping every input combination, sampling the output, and comparing the captured truth table against an expected vector. It drives the netlist's inputs, owns the sample timing (including a programmable settle interval), and reports the observed table, a pass flag, the mismatch count and the first failing row. It sits in the synthesis-verification harness between the testbench/host and each synthesized gate-level module.

## Interface
- N_INPUTS, 3: number of netlist inputs; rows = 2^N_INPUTS; legal 1..8
- SETTLE_CYCLES, 2: extra hold cycles before sampling each row; legal 0..255
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; honoured only when not busy
- expected  in  2^N_INPUTS  expected table; bit k = output for input row k; latched at start
- dut_inp  out  N_INPUTS  applied row; dut_inp[N_INPUTS-1] is the MSB (first-listed input)
- dut_out  in  1  netlist output
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, results valid
- observed  out  2^N_INPUTS  captured table, bit k = sampled dut_out for row k
- match  out  1  observed == latched expected
- mismatch_count  out  N_INPUTS+1  popcount(observed ^ expected)
- first_fail  out  N_INPUTS  lowest row index that mismatched; 0 when match

## Operation
- States: IDLE, HOLD, FINISH.
- IDLE: busy=0. On start=1: latch expected into exp_q, clear observed, mismatch_count, first_fail, match and the internal first-fail-seen flag; set row=0, settle=0; go to HOLD.
- HOLD: dut_inp=row. settle increments each cycle. When settle==SETTLE_CYCLES: observed[row]<=dut_out; if dut_out!=exp_q[row], increment mismatch_count, and if this is the first mismatch record first_fail<=row. Then, if row==2^N_INPUTS-1, go to FINISH; else row<=row+1 and settle<=0.
- FINISH: one cycle; match<=(mismatch_count==0); done pulses; return to IDLE.
- Results (observed, match, mismatch_count, first_fail) hold their values until the next accepted start or rst.
- start while busy=1: ignored. Changes to expected after start: ignored.
- Arithmetic: row is N_INPUTS bits and does not wrap, because the terminal row exits HOLD. mismatch_count is N_INPUTS+1 bits so it can reach 2^N_INPUTS without overflow.

## Timing
- Reset values: dut_inp=0, busy=0, done=0, observed=0, match=0, mismatch_count=0, first_fail=0, state=IDLE.
- rst mid-sweep: the next edge forces all reset values and aborts the sweep; no done pulse.
- Edge E0 samples start=1. busy=1 and dut_inp=0 from E0.
- Each row holds dut_inp for exactly SETTLE_CYCLES+1 cycles. dut_out is sampled at the last edge of that window.
- The sample of the final row occurs at edge E_{R·(SETTLE_CYCLES+1)}, with R=2^N_INPUTS. Call this edge E_s.
- FINISH lasts one cycle, starting at E_s. done=1 and the final results are visible during the cycle after E_s+1. busy falls at that same edge.
- Total latency from start edge to the done cycle: R·(SETTLE_CYCLES+1)+1 edges.
- dut_inp holds the last row through FINISH. It returns to 0 in IDLE after done.
- Back-to-back: start=1 during the done cycle is accepted at the next edge, because the block is in IDLE during that cycle.

## Structure
- Package truth_table_pkg:
  - state enum {IDLE, HOLD, FINISH}
  - function rows(n)=1<<n
  - width constants for row, settle and count
- Sub-module tt_row_checker: combinational compare of the sampled bit against exp_q[row]. It returns the mismatch bit, used to drive the count and first_fail update.
- Top level: FSM plus the row/settle counters.

## Test plan
- Reference 3-input function with N_INPUTS=3, SETTLE_CYCLES=2:
  - bench models out=1 for rows 011, 101 and 110; expected=8'h68
  - required: observed=8'h68, match=1, mismatch_count=0, first_fail=0
  - done occurs 25 edges after start
- Same model with expected=8'h69: match=0, mismatch_count=1, first_fail=0. With expected=8'h60: mismatch_count=1, first_fail=3.
- SETTLE_CYCLES=0, dut_out tied 1, expected=8'h00:
  - each row is held exactly 1 cycle
  - observed=8'hFF, mismatch_count=8, first_fail=0, done at edge 9
- rst asserted at edge 10 of a sweep: all outputs reach reset values next cycle, no done. A fresh start then completes normally.
- start pulsed mid-sweep and expected changed mid-sweep: no restart occurs, and the results are computed against the value latched at start.
- start held high through done: a second sweep begins immediately. observed is cleared at that start, and the second done arrives 25 edges later.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package truth_table_pkg;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Settle counter width: enough for the largest legal settle interval (255)
    localparam int SETTLE_W = 8;

    // Number of truth-table rows for an n-input netlist
    function automatic int rows(input int n);
        return 1 << n;
    endfunction

    // Row index width: one bit per netlist input
    function automatic int row_w(input int n);
        return n;
    endfunction

    // Mismatch counter width: one extra bit so a fully wrong table (2^n) fits
    function automatic int count_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Host/netlist-facing signal bundle of the truth-table sweeper.
interface truth_table_sweeper_if #(
    parameter int N_INPUTS = 3
);
    import truth_table_pkg::*;

    localparam int ROWS = rows(N_INPUTS);

    logic                  start;
    logic [ROWS-1:0]       expected;
    logic [N_INPUTS-1:0]   dut_inp;
    logic                  dut_out;
    logic                  busy;
    logic                  done;
    logic [ROWS-1:0]       observed;
    logic                  match;
    logic [N_INPUTS:0]     mismatch_count;
    logic [N_INPUTS-1:0]   first_fail;

    // Host side: issues sweeps, supplies the netlist output, reads results
    modport master (
        output start,
        output expected,
        output dut_out,
        input  dut_inp,
        input  busy,
        input  done,
        input  observed,
        input  match,
        input  mismatch_count,
        input  first_fail
    );

    // Sweeper side
    modport slave (
        input  start,
        input  expected,
        input  dut_out,
        output dut_inp,
        output busy,
        output done,
        output observed,
        output match,
        output mismatch_count,
        output first_fail
    );

endinterface

// File: rtl/truth_table_sweeper_row_checker.sv
// Compares one sampled netlist output bit against the expected bit of the current row.
module tt_row_checker
    import truth_table_pkg::*;
#(
    parameter int N_INPUTS = 3
) (
    input  logic [rows(N_INPUTS)-1:0] exp_vec,
    input  logic [N_INPUTS-1:0]       row,
    input  logic                      sample,
    output logic                      mismatch
);

    localparam int ROWS = rows(N_INPUTS);

    // One-hot select of the expected bit: only the addressed row can contribute
    logic [ROWS-1:0] exp_hit;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_sel
            assign exp_hit[gi] = (row == N_INPUTS'(gi)) && exp_vec[gi];
        end
    endgenerate

    assign mismatch = sample ^ (|exp_hit);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input row of a single-output combinational netlist, samples its
// output after a programmable settle interval and grades the captured table.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int N_INPUTS      = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.slave  bus
);

    localparam int ROWS  = rows(N_INPUTS);
    localparam int ROW_W = row_w(N_INPUTS);
    localparam int CNT_W = count_w(N_INPUTS);

    localparam logic [ROW_W-1:0]    LAST_ROW    = ROW_W'(ROWS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [ROW_W-1:0]    ROW_ONE     = ROW_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

    state_t                state_q,      state_d;
    logic [ROW_W-1:0]      row_q,        row_d;
    logic [SETTLE_W-1:0]   settle_q,     settle_d;
    logic [ROWS-1:0]       exp_q,        exp_d;
    logic [ROWS-1:0]       observed_q,   observed_d;
    logic [CNT_W-1:0]      mismatch_q,   mismatch_d;
    logic [ROW_W-1:0]      first_fail_q, first_fail_d;
    logic                  seen_fail_q,  seen_fail_d;
    logic                  match_q,      match_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;

    logic                  row_mismatch;
    logic                  sample_now;

    // The sample point is the last cycle of a row's hold window
    assign sample_now = (settle_q == SETTLE_LAST);

    tt_row_checker #(
        .N_INPUTS (N_INPUTS)
    ) u_row_checker (
        .exp_vec  (exp_q),
        .row      (row_q),
        .sample   (bus.dut_out),
        .mismatch (row_mismatch)
    );

    // Next-state logic for the sequencer, row/settle counters and result registers
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        settle_d     = settle_q;
        exp_d        = exp_q;
        observed_d   = observed_q;
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
        seen_fail_d  = seen_fail_q;
        match_d      = match_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                row_d  = '0;
                if (bus.start) begin
                    // Expected table is frozen here; later changes are ignored
                    exp_d        = bus.expected;
                    observed_d   = '0;
                    mismatch_d   = '0;
                    first_fail_d = '0;
                    seen_fail_d  = 1'b0;
                    match_d      = 1'b0;
                    row_d        = '0;
                    settle_d     = '0;
                    busy_d       = 1'b1;
                    state_d      = HOLD;
                end
            end

            HOLD: begin
                if (sample_now) begin
                    observed_d[row_q] = bus.dut_out;
                    if (row_mismatch) begin
                        mismatch_d = mismatch_q + CNT_ONE;
                        if (!seen_fail_q) begin
                            first_fail_d = row_q;
                            seen_fail_d  = 1'b1;
                        end
                    end
                    // Terminal row leaves HOLD, so the row counter never wraps
                    if (row_q == LAST_ROW) begin
                        state_d = FINISH;
                    end else begin
                        row_d    = row_q + ROW_ONE;
                        settle_d = '0;
                    end
                end else begin
                    settle_d = settle_q + SETTLE_ONE;
                end
            end

            FINISH: begin
                // Last row stays applied through this cycle; drop to 0 on exit
                match_d  = (mismatch_q == '0);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                row_d    = '0;
                settle_d = '0;
                state_d  = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                row_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; synchronous reset aborts any sweep in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            settle_q     <= '0;
            exp_q        <= '0;
            observed_q   <= '0;
            mismatch_q   <= '0;
            first_fail_q <= '0;
            seen_fail_q  <= 1'b0;
            match_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            settle_q     <= settle_d;
            exp_q        <= exp_d;
            observed_q   <= observed_d;
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
            seen_fail_q  <= seen_fail_d;
            match_q      <= match_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.dut_inp        = row_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.observed       = observed_q;
    assign bus.match          = match_q;
    assign bus.mismatch_count = mismatch_q;
    assign bus.first_fail     = first_fail_q;

endmodule
